operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter XLEN, 32, operand/result width in bits.
REQ-002 Parameter NREG, 32, number of architectural registers (address width log2(NREG) = 5).
REQ-003 Parameter OPW, 4, ALU opcode width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream instruction present.
REQ-007 in_ready  output  1  stage accepts instruction this cycle.
REQ-008 rs1_addr, rs2_addr  input  5 each  source register addresses.
REQ-009 rd_addr_in  input  5  destination address, passed through.
REQ-010 op_in  input  OPW  ALU opcode, passed through.
REQ-011 wb_en  input  1  writeback strobe.
REQ-012 wb_addr  input  5  writeback register address.
REQ-013 wb_data  input  XLEN  writeback value.
REQ-014 flush  input  1  discard held/incoming instruction.
REQ-015 out_valid  output  1  operands valid toward ALU.
REQ-016 out_ready  input  1  ALU stage consumes this cycle.
REQ-017 rs1, rs2  output  XLEN each  operand values driving ALU rs1/rs2.
REQ-018 rd_addr_out  output  5; op_out  output  OPW  registered pass-through.

Function
REQ-019 Register file SHALL hold NREG x XLEN; register 0 SHALL always read 0; writes with wb_addr=0 SHALL be ignored.
REQ-020 Write SHALL occur on rising clk when wb_en=1, wb_addr!=0.
REQ-021 Read SHALL bypass: if wb_en=1, wb_addr!=0, wb_addr==rsX_addr in the same cycle, captured rsX SHALL be wb_data, not the old register value.
REQ-022 in_ready SHALL be combinational: !out_valid || out_ready.
REQ-023 Capture (in_valid && in_ready && !flush): next cycle out_valid=1, rs1/rs2/rd_addr_out/op_out from that cycle's inputs; latency exactly 1 cycle.
REQ-024 Consume without new capture (out_valid && out_ready, no capture): out_valid SHALL go 0 next cycle.
REQ-025 Stall (out_valid && !out_ready): rd_addr_out, op_out and held source addresses SHALL remain stable.
REQ-026 During stall, a writeback matching a held source address (nonzero) SHALL update the corresponding held rs1/rs2 next cycle; both operands updated if both match.
REQ-027 flush=1 SHALL force out_valid=0 next cycle regardless of in_valid/out_ready; flush SHALL NOT block register-file writes.
REQ-028 Back-to-back: capture and consume in the same cycle SHALL sustain one instruction per cycle.
REQ-029 When out_valid=0, rs1/rs2/rd_addr_out/op_out SHALL hold last values (don't-care to consumer).

Reset
REQ-030 rst_n=0 SHALL immediately clear out_valid, rs1, rs2, rd_addr_out, op_out and all registers to 0, independent of clk.
REQ-031 Reset mid-stall SHALL drop the held instruction; first capture SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 XLEN, NREG, register-address width, OPW and opcode constants SHALL live in the shared ALU package/include used by the ALU blocks.
REQ-033 Register storage and bypass SHALL be a sub-module reg_file_2r1w (2 combinational read ports, 1 synchronous write port, async active-low clear).

Verification
REQ-034 Reset: after rst_n low, rs1_addr=5, rs2_addr=0, capture -> rs1=0, rs2=0, out_valid=1 one cycle later.
REQ-035 Write/read: write x3=2 then capture rs1=x3, rs2=x1 (x1=1) -> rs1=2, rs2=1 to ALU; alu_sra rd=1.
REQ-036 Bypass: same cycle wb x7=32'h80000000 and capture rs1_addr=7 -> rs1=32'h80000000.
REQ-037 x0: wb_en=1, wb_addr=0, wb_data=5, then read x0 -> rs1=0.
REQ-038 Stall refresh: out_ready=0 with held rs2_addr=4, wb x4=9 -> rs2=9 next cycle, in_ready=0, rd_addr_out unchanged.
REQ-039 Flush/throughput: 4 back-to-back captures with out_ready=1 -> 4 consecutive out_valid cycles; flush on 3rd -> that slot out_valid=0.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared ALU definitions: datapath widths, register-file geometry, ALU
// opcode encodings and the operand-fetch occupancy states.
package operand_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RAW  = $clog2(NREG);
  localparam int unsigned OPW  = 4;

  typedef enum logic [OPW-1:0] {
    alu_add  = 4'd0,
    alu_sub  = 4'd1,
    alu_and  = 4'd2,
    alu_or   = 4'd3,
    alu_xor  = 4'd4,
    alu_sll  = 4'd5,
    alu_srl  = 4'd6,
    alu_sra  = 4'd7,
    alu_slt  = 4'd8,
    alu_sltu = 4'd9
  } alu_op_e;

  // Whether the output slot toward the ALU currently holds an instruction.
  typedef enum logic {
    of_empty = 1'b0,
    of_full  = 1'b1
  } of_state_e;

  // A writeback that really lands in the register file and targets addr.
  function automatic logic wb_hits(input logic we, input logic [RAW-1:0] waddr,
                                   input logic [RAW-1:0] addr);
    return we && (waddr != '0) && (waddr == addr);
  endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// reg_file_2r1w: NREG x XLEN register file, two combinational read ports
// with write-to-read bypass, one synchronous write port, async active-low
// clear. Register 0 reads as zero and ignores writes.
//   clk, rst_n        clock / async active-low clear
//   we, waddr, wdata  write port (takes effect on rising clk)
//   raddrN, rdataN    combinational read ports (N = 1, 2)
module reg_file_2r1w #(
  parameter int unsigned XLEN = operand_fetch_pkg::XLEN,
  parameter int unsigned NREG = operand_fetch_pkg::NREG,
  parameter int unsigned AW   = operand_fetch_pkg::RAW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2
);
  import operand_fetch_pkg::*;

  logic [NREG-1:0][XLEN-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle writeback is forwarded so a reader never sees the stale value.
  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) begin
      rdata1 = wb_hits(we, waddr, raddr1) ? wdata : mem[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) begin
      rdata2 = wb_hits(we, waddr, raddr2) ? wdata : mem[raddr2];
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-ALU stage. Reads two source operands (with
// writeback bypass), registers them together with rd/opcode behind a
// single-entry valid/ready slot, and keeps held operands coherent with
// writebacks while the ALU stalls.
//   in_valid/in_ready     upstream handshake
//   rs1_addr, rs2_addr    source register addresses
//   rd_addr_in, op_in     passed through to rd_addr_out, op_out
//   wb_en/wb_addr/wb_data register writeback port
//   flush                 discard held and incoming instruction
//   out_valid/out_ready   ALU handshake; rs1, rs2 operand values
module operand_fetch #(
  parameter int unsigned XLEN = operand_fetch_pkg::XLEN,
  parameter int unsigned NREG = operand_fetch_pkg::NREG,
  parameter int unsigned OPW  = operand_fetch_pkg::OPW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  input  logic [$clog2(NREG)-1:0] rd_addr_in,
  input  logic [OPW-1:0]          op_in,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         rs1,
  output logic [XLEN-1:0]         rs2,
  output logic [$clog2(NREG)-1:0] rd_addr_out,
  output logic [OPW-1:0]          op_out
);
  import operand_fetch_pkg::*;

  localparam int unsigned AW = $clog2(NREG);

  of_state_e       state, state_next;
  logic            capture, stall;
  logic [AW-1:0]   held_rs1, held_rs2;
  logic [AW-1:0]   raddr1, raddr2;
  logic [XLEN-1:0] rdata1, rdata2;

  assign out_valid = (state == of_full);
  assign in_ready  = !out_valid || out_ready;
  assign capture   = in_valid && in_ready && !flush;
  assign stall     = out_valid && !out_ready;

  // While stalled the read ports look at the held addresses, so reloading
  // from them each cycle picks up any matching writeback via the bypass.
  assign raddr1 = stall ? held_rs1 : rs1_addr;
  assign raddr2 = stall ? held_rs2 : rs2_addr;

  reg_file_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= of_empty;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = of_empty;
    end else if (capture) begin
      state_next = of_full;
    end else if (out_ready) begin
      state_next = of_empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1         <= '0;
      rs2         <= '0;
      held_rs1    <= '0;
      held_rs2    <= '0;
      rd_addr_out <= '0;
      op_out      <= '0;
    end else if (capture) begin
      rs1         <= rdata1;
      rs2         <= rdata2;
      held_rs1    <= rs1_addr;
      held_rs2    <= rs2_addr;
      rd_addr_out <= rd_addr_in;
      op_out      <= op_in;
    end else if (stall) begin
      rs1 <= rdata1;
      rs2 <= rdata2;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr_in, wb_addr, rd_addr_out;
  logic [3:0]  op_in, op_out;
  logic        wb_en, flush, out_valid, out_ready;
  logic [31:0] wb_data, rs1, rs2;

  operand_fetch #(.XLEN(32), .NREG(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr_in(rd_addr_in),
    .op_in(op_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .rs1(rs1), .rs2(rs2), .rd_addr_out(rd_addr_out), .op_out(op_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a1, a2, rd;
    logic [3:0]  op;
    logic [31:0] v1, v2;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model, advanced at each rising edge from the inputs in force.
  // A held operand always equals the current architectural register value,
  // because every write to it while held must be reflected.
  task automatic cycle();
    logic rdy_m;
    exp_t e;
    @(posedge clk);
    if (rst_n) begin
      rdy_m = (sb.size() == 0) || out_ready;
      if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
      if (sb.size() != 0 && !out_ready) begin
        e = sb[0];
        e.v1 = mregs[e.a1];
        e.v2 = mregs[e.a2];
        sb[0] = e;
      end
      if (flush) sb.delete();
      if (in_valid && rdy_m && !flush) begin
        e.a1 = rs1_addr; e.a2 = rs2_addr; e.rd = rd_addr_in; e.op = op_in;
        e.v1 = mregs[rs1_addr]; e.v2 = mregs[rs2_addr];
        sb.push_back(e);
      end
    end
    #1;
  endtask

  task automatic issue(input logic iv, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd, input logic [3:0] op, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl, input logic ordy);
    in_valid = iv; rs1_addr = a1; rs2_addr = a2; rd_addr_in = rd; op_in = op;
    wb_en = we; wb_addr = wa; wb_data = wd; flush = fl; out_ready = ordy;
    cycle();
  endtask

  // Monitor: compares the presented slot against the scoreboard head and
  // retires it when the ALU side accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() == 0) || out_ready});
      if (sb.size() != 0) begin
        chk("rs1", rs1, sb[0].v1);
        chk("rs2", rs2, sb[0].v2);
        chk("rd_addr_out", {27'd0, rd_addr_out}, {27'd0, sb[0].rd});
        chk("op_out", {28'd0, op_out}, {28'd0, sb[0].op});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    rst_n = 1'b0;
    in_valid = 0; rs1_addr = 0; rs2_addr = 0; rd_addr_in = 0; op_in = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
    #3;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset rs1", rs1, 32'd0);
    chk("reset rs2", rs2, 32'd0);
    chk("reset rd_addr_out", {27'd0, rd_addr_out}, 32'd0);
    chk("reset op_out", {28'd0, op_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Capture right after reset: x5 and x0 both read 0.
    issue(1, 5'd5, 5'd0, 5'd2, alu_add, 0, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 0, 1, 5'd1, 32'd1, 0, 1);
    issue(0, 0, 0, 0, 0, 1, 5'd3, 32'd2, 0, 1);
    issue(1, 5'd3, 5'd1, 5'd1, alu_sra, 0, 0, 0, 0, 1);
    // Bypass of a same-cycle writeback.
    issue(1, 5'd7, 5'd3, 5'd4, alu_or, 1, 5'd7, 32'h8000_0000, 0, 1);
    // Writes to x0 are dropped.
    issue(0, 0, 0, 0, 0, 1, 5'd0, 32'd5, 0, 1);
    issue(1, 5'd0, 5'd7, 5'd6, alu_xor, 0, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Stall with writeback to a held source.
    issue(1, 5'd1, 5'd4, 5'd9, alu_sub, 0, 0, 0, 0, 0);
    issue(1, 5'd2, 5'd2, 5'd3, alu_and, 1, 5'd4, 32'd9, 0, 0);
    issue(0, 0, 0, 0, 0, 1, 5'd1, 32'h55, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Back-to-back captures, flush on the third.
    issue(1, 5'd1, 5'd3, 5'd10, alu_add, 0, 0, 0, 0, 1);
    issue(1, 5'd3, 5'd4, 5'd11, alu_sll, 0, 0, 0, 0, 1);
    issue(1, 5'd4, 5'd7, 5'd12, alu_srl, 1, 5'd2, 32'h77, 1, 1);
    issue(1, 5'd2, 5'd1, 5'd13, alu_slt, 0, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Reset while stalled drops the held instruction.
    issue(1, 5'd4, 5'd2, 5'd14, alu_sltu, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    #1;
    chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset rs2", rs2, 32'd0);
    chk("midreset rd_addr_out", {27'd0, rd_addr_out}, 32'd0);
    #2;
    rst_n = 1'b1;
    issue(1, 5'd4, 5'd2, 5'd15, alu_add, 0, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      issue($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
            $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end
    for (int n = 0; n < 4; n++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
